cfg_initiator: RTL and testbench

- Controller-side initiator for the chip configuration protocol.
- Accepts write/read commands from the host-side logic, builds 64-bit config packets (with magic number and parity), and loads them into the TX UART.
- Matches returning read-reply packets from the RX UART and reports the result.
- Forwards every non-reply RX packet (data, pass-along) on a separate packet output.
- Sits at the root of the chip chain, opposite the per-chip comms controller.

---
 rtl/cfg_proto_pkg.sv | 48 ++++
 rtl/cfg_rx_filter.sv | 62 ++++++
 rtl/cfg_initiator.sv | 167 ++++++++++++++++
 tb/tb_cfg_initiator.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_proto_pkg.sv
// Shared constants, field positions and types for the chip configuration protocol.
package cfg_proto_pkg;

  localparam logic [1:0]  CONFIG_WRITE_OP = 2'b10;
  localparam logic [1:0]  CONFIG_READ_OP  = 2'b11;
  localparam logic [31:0] MAGIC_NUMBER    = 32'h89504E47;

  localparam int unsigned OP_LSB    = 0;
  localparam int unsigned CHIP_LSB  = 2;
  localparam int unsigned ADDR_LSB  = 10;
  localparam int unsigned DATA_LSB  = 18;
  localparam int unsigned MAGIC_LSB = 26;
  localparam int unsigned REPLY_BIT = 62;
  localparam int unsigned PKT_BITS  = 64;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_TIMEOUT = 2'd1,
    RSP_DONE    = 2'd2
  } rsp_status_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    TX_START = 3'd2,
    TX_WAIT  = 3'd3,
    WAIT_RSP = 3'd4
  } state_e;

  // Top bit carries odd parity over everything below it.
  function automatic logic [PKT_BITS-1:0] build_packet(
    input logic       write,
    input logic [7:0] chip,
    input logic [7:0] addr,
    input logic [7:0] data
  );
    logic [PKT_BITS-1:0] pkt;
    pkt                  = '0;
    pkt[OP_LSB +: 2]     = write ? CONFIG_WRITE_OP : CONFIG_READ_OP;
    pkt[CHIP_LSB +: 8]   = chip;
    pkt[ADDR_LSB +: 8]   = addr;
    pkt[DATA_LSB +: 8]   = write ? data : 8'h00;
    pkt[MAGIC_LSB +: 32] = MAGIC_NUMBER;
    pkt[PKT_BITS-1]      = ~^pkt[PKT_BITS-2:0];
    return pkt;
  endfunction

endpackage

// File: rtl/cfg_rx_filter.sv
// RX word front end: rising-edge detect, parity check, read-reply match and
// registered forwarding of every good word that is not consumed as a reply.
module cfg_rx_filter
  import cfg_proto_pkg::*;
#(
  parameter int unsigned WIDTH     = 64,
  parameter logic [7:0]  GLOBAL_ID = 8'hFF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_data_flag,
  input  logic             waiting,
  input  logic [7:0]       cmd_chip_id,
  input  logic [7:0]       cmd_addr,
  output logic             reply,
  output logic [WIDTH-2:0] pkt_out,
  output logic             pkt_out_valid,
  output logic [15:0]      parity_errors
);

  logic flag_q;
  logic new_word;
  logic good;
  logic match;
  logic forward;

  assign new_word = rx_data_flag && !flag_q;
  assign good     = ^rx_data;

  always_comb begin
    match = good
         && (rx_data[OP_LSB +: 2] == CONFIG_READ_OP)
         && rx_data[REPLY_BIT]
         && (rx_data[MAGIC_LSB +: 32] == MAGIC_NUMBER)
         && (rx_data[ADDR_LSB +: 8] == cmd_addr)
         && ((rx_data[CHIP_LSB +: 8] == cmd_chip_id) || (cmd_chip_id == GLOBAL_ID));
  end

  // A reply is only consumed while a read is outstanding; otherwise it is just traffic.
  assign reply   = new_word && waiting && match;
  assign forward = new_word && good && !reply;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_q        <= 1'b0;
      pkt_out       <= '0;
      pkt_out_valid <= 1'b0;
      parity_errors <= '0;
    end else begin
      flag_q        <= rx_data_flag;
      pkt_out_valid <= forward;
      if (forward) begin
        pkt_out <= rx_data[WIDTH-2:0];
      end
      if (new_word && !good && (parity_errors != '1)) begin
        parity_errors <= parity_errors + 16'd1;
      end
    end
  end

endmodule

// File: rtl/cfg_initiator.sv
// Root-of-chain configuration initiator: builds write/read packets for the TX UART,
// matches read replies from the RX UART and reports OK / TIMEOUT / DONE.
module cfg_initiator
  import cfg_proto_pkg::*;
#(
  parameter int unsigned WIDTH          = 64,
  parameter logic [7:0]  GLOBAL_ID      = 8'hFF,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [7:0]       cmd_chip_id,
  input  logic [7:0]       cmd_addr,
  input  logic [7:0]       cmd_data,
  output logic [WIDTH-1:0] tx_data,
  output logic             ld_tx_data,
  input  logic             tx_busy,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_data_flag,
  output logic             rsp_valid,
  output logic [1:0]       rsp_status,
  output logic [7:0]       rsp_chip_id,
  output logic [7:0]       rsp_data,
  output logic [WIDTH-2:0] pkt_out,
  output logic             pkt_out_valid,
  output logic [15:0]      parity_errors,
  output logic [15:0]      timeouts
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state, state_next;
  rsp_status_e rsp_status_q, rsp_status_next;
  logic        cmd_write_q;
  logic [7:0]  cmd_chip_q, cmd_addr_q;
  logic        start_cnt, start_cnt_next;
  logic [15:0] timer, timer_next;
  logic        ld_next, rsp_valid_next, timeout_inc;
  logic [7:0]  rsp_chip_next, rsp_data_next;
  logic        accept, broadcast, reply, waiting;

  assign accept     = cmd_valid && cmd_ready;
  assign broadcast  = (cmd_chip_q == GLOBAL_ID);
  assign waiting    = (state == WAIT_RSP);
  assign rsp_status = rsp_status_q;

  cfg_rx_filter #(
    .WIDTH     (WIDTH),
    .GLOBAL_ID (GLOBAL_ID)
  ) u_rx_filter (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx_data       (rx_data),
    .rx_data_flag  (rx_data_flag),
    .waiting       (waiting),
    .cmd_chip_id   (cmd_chip_q),
    .cmd_addr      (cmd_addr_q),
    .reply         (reply),
    .pkt_out       (pkt_out),
    .pkt_out_valid (pkt_out_valid),
    .parity_errors (parity_errors)
  );

  always_comb begin
    state_next      = state;
    start_cnt_next  = start_cnt;
    timer_next      = timer;
    ld_next         = 1'b0;
    rsp_valid_next  = 1'b0;
    rsp_status_next = RSP_OK;
    rsp_chip_next   = '0;
    rsp_data_next   = '0;
    timeout_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = LOAD;
      end
      LOAD: begin
        if (!tx_busy) begin
          ld_next        = 1'b1;
          start_cnt_next = 1'b0;
          state_next     = TX_START;
        end
      end
      TX_START: begin
        // Give the UART two cycles to raise busy, then move on regardless.
        if (tx_busy || start_cnt) state_next = TX_WAIT;
        else                      start_cnt_next = 1'b1;
      end
      TX_WAIT: begin
        if (!tx_busy) begin
          if (cmd_write_q) begin
            rsp_valid_next = 1'b1;
            rsp_chip_next  = cmd_chip_q;
            state_next     = IDLE;
          end else begin
            timer_next = '0;
            state_next = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        timer_next = timer + 16'd1;
        if (reply) begin
          rsp_valid_next = 1'b1;
          rsp_chip_next  = rx_data[CHIP_LSB +: 8];
          rsp_data_next  = rx_data[DATA_LSB +: 8];
          if (broadcast) timer_next = '0;
          else           state_next = IDLE;
        end else if (timer == TIMEOUT_LAST) begin
          rsp_valid_next = 1'b1;
          rsp_chip_next  = cmd_chip_q;
          state_next     = IDLE;
          if (broadcast) begin
            rsp_status_next = RSP_DONE;
          end else begin
            rsp_status_next = RSP_TIMEOUT;
            timeout_inc     = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cmd_ready    <= 1'b0;
      cmd_write_q  <= 1'b0;
      cmd_chip_q   <= '0;
      cmd_addr_q   <= '0;
      tx_data      <= '0;
      ld_tx_data   <= 1'b0;
      start_cnt    <= 1'b0;
      timer        <= '0;
      rsp_valid    <= 1'b0;
      rsp_status_q <= RSP_OK;
      rsp_chip_id  <= '0;
      rsp_data     <= '0;
      timeouts     <= '0;
    end else begin
      state        <= state_next;
      cmd_ready    <= (state_next == IDLE);
      ld_tx_data   <= ld_next;
      start_cnt    <= start_cnt_next;
      timer        <= timer_next;
      rsp_valid    <= rsp_valid_next;
      rsp_status_q <= rsp_status_next;
      rsp_chip_id  <= rsp_chip_next;
      rsp_data     <= rsp_data_next;
      if (accept) begin
        cmd_write_q <= cmd_write;
        cmd_chip_q  <= cmd_chip_id;
        cmd_addr_q  <= cmd_addr;
        tx_data     <= WIDTH'(build_packet(cmd_write, cmd_chip_id, cmd_addr, cmd_data));
      end
      if (timeout_inc && (timeouts != '1)) begin
        timeouts <= timeouts + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cfg_initiator.sv
// Directed bench for cfg_initiator: table of write/read transactions plus
// hand-written sequences for timeout, broadcast, forwarding, TX stall and reset.
module tb_cfg_initiator;

  localparam int unsigned TO = 200;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_chip_id = '0;
  logic [7:0]  cmd_addr = '0;
  logic [7:0]  cmd_data = '0;
  logic        tx_busy = 1'b0;
  logic [63:0] rx_data = '0;
  logic        rx_data_flag = 1'b0;
  logic        cmd_ready;
  logic [63:0] tx_data;
  logic        ld_tx_data;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [7:0]  rsp_chip_id;
  logic [7:0]  rsp_data;
  logic [62:0] pkt_out;
  logic        pkt_out_valid;
  logic [15:0] parity_errors;
  logic [15:0] timeouts;

  cfg_initiator #(
    .WIDTH          (64),
    .GLOBAL_ID      (8'hFF),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_chip_id   (cmd_chip_id),
    .cmd_addr      (cmd_addr),
    .cmd_data      (cmd_data),
    .tx_data       (tx_data),
    .ld_tx_data    (ld_tx_data),
    .tx_busy       (tx_busy),
    .rx_data       (rx_data),
    .rx_data_flag  (rx_data_flag),
    .rsp_valid     (rsp_valid),
    .rsp_status    (rsp_status),
    .rsp_chip_id   (rsp_chip_id),
    .rsp_data      (rsp_data),
    .pkt_out       (pkt_out),
    .pkt_out_valid (pkt_out_valid),
    .parity_errors (parity_errors),
    .timeouts      (timeouts)
  );

  typedef struct {
    logic        wr;
    logic [7:0]  chip;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [25:0] exp_low;
    logic [7:0]  exp_rdata;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          ld_count = 0, rsp_count = 0, pkt_count = 0, coincide = 0;
  logic [1:0]  last_status;
  logic [7:0]  last_chip, last_data;
  logic        last_ready;
  int unsigned last_rsp_cyc;
  logic [62:0] last_pkt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ld_tx_data) ld_count++;
    if (rsp_valid) begin
      rsp_count++;
      last_status  = rsp_status;
      last_chip    = rsp_chip_id;
      last_data    = rsp_data;
      last_ready   = cmd_ready;
      last_rsp_cyc = cyc;
    end
    if (pkt_out_valid) begin
      pkt_count++;
      last_pkt = pkt_out;
    end
    if (rsp_valid && pkt_out_valid) coincide++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_word(input logic [1:0] op, input logic [7:0] chip,
                                          input logic [7:0] addr, input logic [7:0] data,
                                          input logic b62, input logic good);
    logic [63:0] w;
    w        = '0;
    w[1:0]   = op;
    w[9:2]   = chip;
    w[17:10] = addr;
    w[25:18] = data;
    w[57:26] = 32'h89504E47;
    w[62]    = b62;
    w[63]    = good ? ~^w[62:0] : ^w[62:0];
    return w;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_ld"}, ld_tx_data, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_status"}, rsp_status, 0);
    check({tag, "_rsp_chip"}, rsp_chip_id, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_pkt_out"}, pkt_out, 0);
    check({tag, "_pkt_valid"}, pkt_out_valid, 0);
    check({tag, "_parity_errors"}, parity_errors, 0);
    check({tag, "_timeouts"}, timeouts, 0);
  endtask

  task automatic issue_cmd(input logic wr, input logic [7:0] chip, input logic [7:0] addr,
                           input logic [7:0] data);
    int unsigned n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("cmd_ready_before_issue", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_chip_id = chip; cmd_addr = addr; cmd_data = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ld();
    int unsigned n = 0;
    while (!ld_tx_data && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ld_tx_data_seen", ld_tx_data, 1);
  endtask

  // UART stand-in: busy for 8 cycles after the load pulse; fall = first edge seeing busy low.
  task automatic serve_tx(output int unsigned fall);
    wait_ld();
    @(posedge clk); #1 tx_busy = 1'b1;
    repeat (8) @(posedge clk);
    #1 tx_busy = 1'b0;
    fall = cyc + 1;
  endtask

  task automatic wait_rsp(input int n0, input int unsigned budget, input string name);
    int unsigned k = 0;
    while (rsp_count == n0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, rsp_count != n0, 1);
  endtask

  task automatic send_rx(input logic [63:0] w);
    @(posedge clk); #1 rx_data = w; rx_data_flag = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 rx_data_flag = 1'b0;
  endtask

  initial begin
    vec_t        vecs[6];
    int unsigned fall, ok3;
    int          n0, p0, ld0;
    logic [63:0] w;

    vecs[0] = '{1'b1, 8'h05, 8'h10, 8'hA5, {8'hA5, 8'h10, 8'h05, 2'b10}, 8'h00};
    vecs[1] = '{1'b1, 8'hFF, 8'h00, 8'h00, {8'h00, 8'h00, 8'hFF, 2'b10}, 8'h00};
    vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'hFF, {8'hFF, 8'hFF, 8'h00, 2'b10}, 8'h00};
    vecs[3] = '{1'b1, 8'h3C, 8'hC3, 8'h5A, {8'h5A, 8'hC3, 8'h3C, 2'b10}, 8'h00};
    vecs[4] = '{1'b0, 8'h05, 8'h10, 8'hEE, {8'h00, 8'h10, 8'h05, 2'b11}, 8'h3C};
    vecs[5] = '{1'b0, 8'h7E, 8'h01, 8'h00, {8'h00, 8'h01, 8'h7E, 2'b11}, 8'hC9};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1);

    for (int i = 0; i < 6; i++) begin
      ld0 = ld_count;
      n0  = rsp_count;
      issue_cmd(vecs[i].wr, vecs[i].chip, vecs[i].addr, vecs[i].data);
      serve_tx(fall);
      check($sformatf("vec%0d_tx_low", i), tx_data[25:0], vecs[i].exp_low);
      check($sformatf("vec%0d_tx_magic", i), tx_data[57:26], 32'h89504E47);
      check($sformatf("vec%0d_tx_pad", i), tx_data[62:58], 0);
      check($sformatf("vec%0d_tx_parity", i), ^tx_data, 1);
      if (!vecs[i].wr) begin
        repeat (5) @(posedge clk);
        check($sformatf("vec%0d_no_early_rsp", i), rsp_count - n0, 0);
        send_rx(mk_word(2'b11, vecs[i].chip, vecs[i].addr, vecs[i].exp_rdata, 1'b1, 1'b1));
      end
      wait_rsp(n0, 40, $sformatf("vec%0d_rsp_arrived", i));
      check($sformatf("vec%0d_status", i), last_status, 0);
      check($sformatf("vec%0d_rsp_chip", i), last_chip, vecs[i].chip);
      check($sformatf("vec%0d_rsp_data", i), last_data, vecs[i].exp_rdata);
      check($sformatf("vec%0d_ready_after", i), last_ready, 1);
      check($sformatf("vec%0d_ld_pulses", i), ld_count - ld0, 1);
    end

    // Unicast read with no reply.
    n0 = rsp_count;
    issue_cmd(1'b0, 8'h21, 8'h44, 8'h00);
    serve_tx(fall);
    wait_rsp(n0, TO + 20, "timeout_arrived");
    check("timeout_status", last_status, 1);
    check("timeout_chip", last_chip, 8'h21);
    check("timeout_data", last_data, 0);
    check("timeout_latency", last_rsp_cyc - fall, TO);
    check("timeout_count", timeouts, 1);

    // Broadcast read: three replies, then DONE after a full idle timeout.
    issue_cmd(1'b0, 8'hFF, 8'h20, 8'h00);
    serve_tx(fall);
    for (int c = 1; c <= 3; c++) begin
      repeat ((c == 1) ? 10 : 97) @(posedge clk);
      n0 = rsp_count;
      send_rx(mk_word(2'b11, 8'(c), 8'h20, 8'h40 + 8'(c), 1'b1, 1'b1));
      wait_rsp(n0, 10, $sformatf("bcast%0d_arrived", c));
      check($sformatf("bcast%0d_status", c), last_status, 0);
      check($sformatf("bcast%0d_chip", c), last_chip, c);
      check($sformatf("bcast%0d_data", c), last_data, 8'h40 + 8'(c));
    end
    ok3 = last_rsp_cyc;
    n0  = rsp_count;
    wait_rsp(n0, TO + 20, "bcast_done_arrived");
    check("bcast_done_status", last_status, 2);
    check("bcast_done_data", last_data, 0);
    check("bcast_done_latency", last_rsp_cyc - ok3, TO);
    check("bcast_timeouts_unchanged", timeouts, 1);

    // Waiting for a reply: data packet, wrong-address reply, bad-parity reply.
    n0 = rsp_count;
    p0 = pkt_count;
    issue_cmd(1'b0, 8'h05, 8'h10, 8'h00);
    serve_tx(fall);
    repeat (3) @(posedge clk);
    w = mk_word(2'b01, 8'h05, 8'h10, 8'h77, 1'b0, 1'b1);
    send_rx(w);
    repeat (2) @(posedge clk); #1;
    check("wait_data_fwd_count", pkt_count - p0, 1);
    check("wait_data_fwd_value", last_pkt, w[62:0]);
    w = mk_word(2'b11, 8'h05, 8'h11, 8'h12, 1'b1, 1'b1);
    send_rx(w);
    repeat (2) @(posedge clk); #1;
    check("wait_wrong_addr_fwd_count", pkt_count - p0, 2);
    check("wait_wrong_addr_fwd_value", last_pkt, w[62:0]);
    send_rx(mk_word(2'b11, 8'h05, 8'h10, 8'h3C, 1'b1, 1'b0));
    repeat (2) @(posedge clk); #1;
    check("wait_parity_errors", parity_errors, 1);
    check("wait_bad_not_fwd", pkt_count - p0, 2);
    check("wait_no_rsp", rsp_count - n0, 0);
    check("wait_still_busy", cmd_ready, 0);
    send_rx(mk_word(2'b11, 8'h05, 8'h10, 8'h66, 1'b1, 1'b1));
    wait_rsp(n0, 10, "wait_final_rsp_arrived");
    check("wait_final_status", last_status, 0);
    check("wait_final_data", last_data, 8'h66);

    // In IDLE even a reply-shaped word is forwarded, one cycle after the rising edge.
    n0 = rsp_count;
    p0 = pkt_count;
    w  = mk_word(2'b11, 8'h05, 8'h10, 8'h5A, 1'b1, 1'b1);
    @(posedge clk); #1 rx_data = w; rx_data_flag = 1'b1;
    @(negedge clk);
    check("idle_fwd_not_yet", pkt_out_valid, 0);
    @(negedge clk);
    check("idle_fwd_valid", pkt_out_valid, 1);
    check("idle_fwd_value", pkt_out, w[62:0]);
    @(negedge clk);
    check("idle_fwd_single_strobe", pkt_out_valid, 0);
    @(posedge clk); #1 rx_data_flag = 1'b0;
    send_rx(mk_word(2'b01, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0));
    repeat (2) @(posedge clk); #1;
    check("idle_parity_errors", parity_errors, 2);
    check("idle_fwd_count", pkt_count - p0, 1);
    check("idle_no_rsp", rsp_count - n0, 0);

    // TX UART stays busy: load must wait.
    ld0 = ld_count;
    n0  = rsp_count;
    @(posedge clk); #1 tx_busy = 1'b1;
    issue_cmd(1'b1, 8'h09, 8'h0A, 8'h0B);
    repeat (50) @(posedge clk);
    check("busy_hold_no_ld", ld_count - ld0, 0);
    #1 tx_busy = 1'b0;
    serve_tx(fall);
    check("busy_hold_one_ld", ld_count - ld0, 1);
    wait_rsp(n0, 40, "busy_hold_rsp_arrived");
    check("busy_hold_status", last_status, 0);
    check("busy_hold_chip", last_chip, 8'h09);

    // Reset while in TX_WAIT.
    ld0 = ld_count;
    n0  = rsp_count;
    issue_cmd(1'b1, 8'h12, 8'h34, 8'h56);
    wait_ld();
    @(posedge clk); #1 tx_busy = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    check_zero("mid_reset");
    tx_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_reset_ready_after", cmd_ready, 1);
    repeat (10) @(posedge clk); #1;
    check("mid_reset_no_reload", ld_count - ld0, 1);
    check("mid_reset_no_rsp", rsp_count - n0, 0);

    check("rsp_pkt_never_coincide", coincide, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
